// File: rtl/multicycle_maindec_pkg.sv
// Shared state encodings, instruction field constants and control-word helper
// for the multicycle main decoder.
package mdec_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTEXEC  = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_IMMEXEC = 4'd10,
        S_JUMP    = 4'd11,
        S_JR      = 4'd12,
        S_JALR    = 4'd13,
        S_TRAP    = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic [1:0] memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       pcwrite;
        logic [1:0] branch;
        logic [1:0] pcsrc;
        logic       byte_enable;
    } ctl_t;

    // Control word for a state; FETCH strobes are later qualified by ready/stall.
    function automatic ctl_t ctl_for(state_t s, logic [5:0] op, logic from_imm);
        ctl_t c;
        logic bytes;
        c     = '0;
        bytes = (op == OP_LB) || (op == OP_SB);
        case (s)
            S_FETCH: begin
                c.mem_req = 1'b1; c.alusrcb = SRCB_FOUR;
                c.irwrite = 1'b1; c.pcwrite = 1'b1;
            end
            S_DECODE:  c.alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; c.byte_enable = bytes;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1; c.iord = 1'b1; c.byte_enable = bytes;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1; c.memtoreg = 2'b01; c.byte_enable = bytes;
            end
            S_MEMWR: begin
                c.mem_req = 1'b1; c.iord = 1'b1; c.memwrite = 1'b1;
                c.byte_enable = bytes;
            end
            S_RTEXEC: begin
                c.alusrca = 1'b1; c.alusrcb = SRCB_RT; c.aluop = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regwrite = 1'b1; c.regdst = ~from_imm;
            end
            S_IMMEXEC: begin
                c.alusrca = 1'b1; c.alusrcb = SRCB_IMM;
                c.aluop   = (op == OP_ADDI) ? ALUOP_ADD : ALUOP_FUNCT;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1; c.alusrcb = SRCB_RT; c.aluop = ALUOP_SUB;
                c.pcsrc   = PCSRC_ALUOUT;
                c.branch  = (op == OP_BNE) ? 2'b11 : 2'b01;
            end
            S_JUMP: begin
                c.pcwrite = 1'b1; c.pcsrc = PCSRC_JUMP;
            end
            S_JR: begin
                c.pcwrite = 1'b1; c.pcsrc = PCSRC_RS;
            end
            S_JALR: begin
                c.pcwrite = 1'b1; c.pcsrc = PCSRC_RS; c.regwrite = 1'b1;
                c.regdst  = 1'b1; c.memtoreg = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_maindec_if.sv
// Instruction/memory/control bundle between the IR, memory and the decoder.
// Handshake: an access in progress (mem_req=1) completes on a cycle with mem_ready=1 and stall=0.
interface multicycle_maindec_if #(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int CNT_W   = 32
);
    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct_pass;
    logic               mem_ready;
    logic               stall;
    logic               mem_req;
    logic               iord;
    logic               irwrite;
    logic               memwrite;
    logic               regwrite;
    logic               regdst;
    logic [1:0]         memtoreg;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         aluop;
    logic               pcwrite;
    logic [1:0]         branch;
    logic [1:0]         pcsrc;
    logic               byte_enable;
    logic [FUNCT_W-1:0] funct;
    logic               illegal;
    logic               retire;
    logic [CNT_W-1:0]   retire_cnt;
    logic [3:0]         state_dbg;

    modport slave (
        input  op, funct_pass, mem_ready, stall,
        output mem_req, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, aluop, pcwrite, branch, pcsrc, byte_enable,
               funct, illegal, retire, retire_cnt, state_dbg
    );

    modport master (
        output op, funct_pass, mem_ready, stall,
        input  mem_req, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, aluop, pcwrite, branch, pcsrc, byte_enable,
               funct, illegal, retire, retire_cnt, state_dbg
    );
endinterface

// File: rtl/multicycle_maindec_functmap.sv
// Effective ALU funct: logical immediates borrow the matching R-type funct code.
module mdec_functmap
    import mdec_pkg::*;
#(
    parameter int FUNCT_W = 6
) (
    input  logic [5:0]         i_op,
    input  logic [FUNCT_W-1:0] i_funct_pass,
    output logic [FUNCT_W-1:0] o_funct
);
    always_comb begin
        case (i_op)
            OP_ORI:  o_funct = FUNCT_W'(FN_OR);
            OP_XORI: o_funct = FUNCT_W'(FN_XOR);
            OP_ANDI: o_funct = FUNCT_W'(FN_AND);
            default: o_funct = i_funct_pass;
        endcase
    end
endmodule

// File: rtl/multicycle_maindec.sv
// Multicycle MIPS-subset main control: registered Moore FSM with memory
// handshake, stall freeze, illegal-opcode trap and retired-instruction counter.
module multicycle_maindec
    import mdec_pkg::*;
#(
    parameter int OP_W         = 6,
    parameter int FUNCT_W      = 6,
    parameter int CNT_W        = 32,
    parameter bit MEM_HS       = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    multicycle_maindec_if.slave bus
);
    state_t           r_state;
    ctl_t             r_ctl;
    logic             r_from_imm;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    state_t     w_nxt;
    logic [5:0] w_op;
    logic [5:0] w_fp;
    logic       w_done;
    logic       w_unknown;
    logic       w_from_imm;
    logic       w_retire;

    assign w_op       = 6'(bus.op);
    assign w_fp       = 6'(bus.funct_pass);
    assign w_done     = MEM_HS ? bus.mem_ready : 1'b1;
    assign w_from_imm = (r_state == S_IMMEXEC) || ((r_state == S_ALUWB) && r_from_imm);
    assign w_unknown  = !(w_op inside {OP_RTYPE, OP_LW, OP_SW, OP_LB, OP_SB, OP_BEQ,
                                       OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_J});

    always_comb begin
        w_nxt = r_state;
        if (!bus.stall) begin
            case (r_state)
                S_IDLE:  w_nxt = S_FETCH;
                S_FETCH: if (w_done) w_nxt = S_DECODE;
                S_DECODE: begin
                    if (w_op inside {OP_LW, OP_SW, OP_LB, OP_SB})  w_nxt = S_MEMADR;
                    else if (w_op == OP_RTYPE)
                        w_nxt = (w_fp == FN_JR)   ? S_JR :
                                (w_fp == FN_JALR) ? S_JALR : S_RTEXEC;
                    else if (w_op inside {OP_BEQ, OP_BNE})         w_nxt = S_BRANCH;
                    else if (w_op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI})
                        w_nxt = S_IMMEXEC;
                    else if (w_op == OP_J)                         w_nxt = S_JUMP;
                    else w_nxt = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
                end
                S_MEMADR:  w_nxt = (w_op inside {OP_LW, OP_LB}) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   if (w_done) w_nxt = S_MEMWB;
                S_MEMWR:   if (w_done) w_nxt = S_FETCH;
                S_RTEXEC:  w_nxt = S_ALUWB;
                S_IMMEXEC: w_nxt = S_ALUWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_JR, S_JALR: w_nxt = S_FETCH;
                S_TRAP:    w_nxt = S_TRAP;
                default:   w_nxt = S_IDLE;
            endcase
        end
    end

    // Retire is tied to the state actually leaving on this edge, so stall masks it.
    assign w_retire = !bus.stall &&
                      ((r_state inside {S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_JR, S_JALR}) ||
                       ((r_state == S_MEMWR) && w_done) ||
                       ((r_state == S_DECODE) && w_unknown && !ILLEGAL_TRAP));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ctl      <= '0;
            r_from_imm <= 1'b0;
            r_illegal  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_nxt;
            r_ctl      <= ctl_for(w_nxt, w_op, w_from_imm);
            r_from_imm <= w_from_imm;
            if (w_nxt == S_TRAP) r_illegal <= 1'b1;
            if (w_retire)        r_cnt     <= r_cnt + 1'b1;
        end
    end

    mdec_functmap #(.FUNCT_W(FUNCT_W)) u_functmap (
        .i_op         (w_op),
        .i_funct_pass (bus.funct_pass),
        .o_funct      (bus.funct)
    );

    assign bus.mem_req     = r_ctl.mem_req;
    assign bus.iord        = r_ctl.iord;
    assign bus.irwrite     = r_ctl.irwrite & w_done & ~bus.stall;
    assign bus.memwrite    = r_ctl.memwrite & ~bus.stall;
    assign bus.regwrite    = r_ctl.regwrite & ~bus.stall;
    assign bus.regdst      = r_ctl.regdst;
    assign bus.memtoreg    = r_ctl.memtoreg;
    assign bus.alusrca     = r_ctl.alusrca;
    assign bus.alusrcb     = r_ctl.alusrcb;
    assign bus.aluop       = r_ctl.aluop;
    assign bus.pcwrite     = r_ctl.pcwrite & ~bus.stall & (w_done | (r_state != S_FETCH));
    assign bus.branch      = bus.stall ? 2'b00 : r_ctl.branch;
    assign bus.pcsrc       = r_ctl.pcsrc;
    assign bus.byte_enable = r_ctl.byte_enable;
    assign bus.illegal     = r_illegal;
    assign bus.retire      = w_retire;
    assign bus.retire_cnt  = r_cnt;
    assign bus.state_dbg   = r_state;

endmodule

// File: tb/tb_multicycle_maindec.sv
// Directed bench for multicycle_maindec: handshaking instance (a) and a
// no-handshake, no-trap instance (b) driven through their interfaces.
module tb_multicycle_maindec;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    multicycle_maindec_if #(.OP_W(6), .FUNCT_W(6), .CNT_W(32)) ba ();
    multicycle_maindec_if #(.OP_W(6), .FUNCT_W(6), .CNT_W(32)) bb ();

    multicycle_maindec #(.OP_W(6), .FUNCT_W(6), .CNT_W(32),
                         .MEM_HS(1'b1), .ILLEGAL_TRAP(1'b1)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ba.slave)
    );

    multicycle_maindec #(.OP_W(6), .FUNCT_W(6), .CNT_W(32),
                         .MEM_HS(1'b0), .ILLEGAL_TRAP(1'b0)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bb.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end, expected $finish before 200us");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and checks happen well after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // From the first FETCH cycle of instance a, complete the fetch immediately.
    task automatic fetch_a();
        ba.mem_ready = 1'b1;
        settle();
        step();
        ba.mem_ready = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        ba.op         = 6'b100011;
        ba.funct_pass = 6'b000000;
        ba.mem_ready  = 1'b0;
        ba.stall      = 1'b0;
        bb.op         = 6'b000000;
        bb.funct_pass = 6'b100000;
        bb.mem_ready  = 1'b0;
        bb.stall      = 1'b1;
        repeat (2) step();

        chk("rst_state",   ba.state_dbg, 4'd0);
        chk("rst_cnt",     ba.retire_cnt, 32'd0);
        chk("rst_illegal", ba.illegal, 1'b0);
        chk("rst_strobes", {ba.mem_req, ba.irwrite, ba.pcwrite, ba.regwrite,
                            ba.memwrite, ba.retire, ba.alusrcb, ba.branch}, 10'd0);

        // lw: FETCH 3 cycles, MEMRD 3 cycles
        reset_n = 1'b1;
        settle();
        chk("lw_idle", ba.state_dbg, 4'd0);
        step();
        chk("lw_fetch0", ba.state_dbg, 4'd1);
        chk("lw_fetch0_req", {ba.mem_req, ba.iord, ba.irwrite, ba.pcwrite}, 4'b1000);
        step();
        chk("lw_fetch1", ba.state_dbg, 4'd1);
        step();
        ba.mem_ready = 1'b1;
        settle();
        chk("lw_fetch2_strb", {ba.irwrite, ba.pcwrite, ba.alusrcb, ba.aluop}, 6'b110100);
        step();
        ba.mem_ready = 1'b0;
        chk("lw_decode", {ba.state_dbg, ba.alusrcb, ba.irwrite}, {4'd2, 2'b11, 1'b0});
        step();
        chk("lw_memadr", {ba.state_dbg, ba.alusrca, ba.alusrcb}, {4'd3, 1'b1, 2'b10});
        step();
        chk("lw_memrd0", {ba.state_dbg, ba.mem_req, ba.iord}, {4'd4, 1'b1, 1'b1});
        step();
        chk("lw_memrd1", ba.state_dbg, 4'd4);
        step();
        ba.mem_ready = 1'b1;
        settle();
        chk("lw_memrd2", {ba.state_dbg, ba.regwrite, ba.retire}, {4'd4, 1'b0, 1'b0});
        step();
        ba.mem_ready = 1'b0;
        chk("lw_memwb", {ba.state_dbg, ba.regwrite, ba.regdst, ba.memtoreg, ba.retire,
                         ba.byte_enable}, {4'd5, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0});
        step();
        chk("lw_done", {ba.state_dbg, ba.retire_cnt}, {4'd1, 32'd1});

        // sb: byte access, memwrite held across the wait
        ba.op = 6'b101000;
        step();
        step();
        ba.mem_ready = 1'b1;
        settle();
        step();
        ba.mem_ready = 1'b0;
        chk("sb_decode", ba.state_dbg, 4'd2);
        step();
        chk("sb_memadr", {ba.state_dbg, ba.byte_enable}, {4'd3, 1'b1});
        step();
        chk("sb_memwr0", {ba.state_dbg, ba.memwrite, ba.byte_enable, ba.retire, ba.regwrite},
            {4'd6, 1'b1, 1'b1, 1'b0, 1'b0});
        step();
        chk("sb_memwr1", {ba.memwrite, ba.iord, ba.mem_req}, 3'b111);
        step();
        ba.mem_ready = 1'b1;
        settle();
        chk("sb_memwr2", {ba.memwrite, ba.retire, ba.regwrite}, 3'b110);
        step();
        ba.mem_ready = 1'b0;
        chk("sb_done", {ba.state_dbg, ba.retire_cnt}, {4'd1, 32'd2});

        // ori: funct remap and rt destination
        ba.op         = 6'b001101;
        ba.funct_pass = 6'b000000;
        fetch_a();
        step();
        chk("ori_immexec", {ba.state_dbg, ba.funct, ba.aluop, ba.alusrcb},
            {4'd10, 6'b100101, 2'b10, 2'b10});
        step();
        chk("ori_aluwb", {ba.state_dbg, ba.regdst, ba.regwrite, ba.memtoreg, ba.retire},
            {4'd8, 1'b0, 1'b1, 2'b00, 1'b1});
        step();
        chk("ori_done", ba.retire_cnt, 32'd3);

        // jalr with a 3-cycle stall in FETCH (ready ignored while stalled)
        ba.op         = 6'b000000;
        ba.funct_pass = 6'b001001;
        ba.stall      = 1'b1;
        ba.mem_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("jalr_stall", {ba.state_dbg, ba.irwrite, ba.pcwrite, ba.mem_req},
                {4'd1, 1'b0, 1'b0, 1'b1});
            step();
        end
        ba.stall = 1'b0;
        settle();
        chk("jalr_fetch_go", ba.irwrite, 1'b1);
        step();
        ba.mem_ready = 1'b0;
        chk("jalr_decode", ba.state_dbg, 4'd2);
        step();
        chk("jalr_exec", {ba.state_dbg, ba.pcsrc, ba.memtoreg, ba.regwrite, ba.regdst,
                          ba.pcwrite, ba.retire}, {4'd13, 2'b11, 2'b10, 4'b1111});
        ba.stall = 1'b1;
        settle();
        chk("jalr_stall_strb", {ba.regwrite, ba.pcwrite, ba.retire}, 3'b000);
        step();
        chk("jalr_stall_hold", {ba.state_dbg, ba.retire_cnt}, {4'd13, 32'd3});
        ba.stall = 1'b0;
        step();
        chk("jalr_done", {ba.state_dbg, ba.retire_cnt}, {4'd1, 32'd4});

        // beq then bne
        ba.op = 6'b000100;
        fetch_a();
        step();
        chk("beq_branch", {ba.state_dbg, ba.branch, ba.aluop, ba.pcsrc, ba.alusrca, ba.retire},
            {4'd9, 2'b01, 2'b01, 2'b01, 1'b1, 1'b1});
        step();
        ba.op = 6'b000101;
        fetch_a();
        step();
        chk("bne_branch", {ba.state_dbg, ba.branch}, {4'd9, 2'b11});
        step();
        chk("br_cnt", ba.retire_cnt, 32'd6);

        // illegal opcode traps, sticky, counter frozen; reset clears
        ba.op = 6'b111111;
        fetch_a();
        settle();
        chk("ill_decode", {ba.state_dbg, ba.retire}, {4'd2, 1'b0});
        step();
        chk("ill_trap", {ba.state_dbg, ba.illegal, ba.retire_cnt}, {4'd14, 1'b1, 32'd6});
        ba.op = 6'b100011;
        step();
        step();
        chk("ill_sticky", {ba.state_dbg, ba.illegal, ba.retire_cnt, ba.mem_req, ba.pcwrite},
            {4'd14, 1'b1, 32'd6, 1'b0, 1'b0});
        #2;
        reset_n = 1'b0;
        settle();
        chk("ill_reset", {ba.state_dbg, ba.illegal, ba.retire_cnt}, {4'd0, 1'b0, 32'd0});

        // instance b: R-type add without handshake, then illegal op as NOP
        bb.stall = 1'b0;
        step();
        reset_n = 1'b1;
        settle();
        chk("b_idle", bb.state_dbg, 4'd0);
        step();
        chk("b_fetch", {bb.state_dbg, bb.irwrite, bb.pcwrite}, {4'd1, 1'b1, 1'b1});
        step();
        chk("b_decode", bb.state_dbg, 4'd2);
        step();
        chk("b_rtexec", {bb.state_dbg, bb.aluop, bb.alusrca, bb.alusrcb, bb.funct},
            {4'd7, 2'b10, 1'b1, 2'b00, 6'b100000});
        step();
        chk("b_aluwb", {bb.state_dbg, bb.regdst, bb.regwrite, bb.retire}, {4'd8, 3'b111});
        step();
        chk("b_done", {bb.state_dbg, bb.retire_cnt}, {4'd1, 32'd1});
        bb.op = 6'b111111;
        step();
        settle();
        chk("b_nop_decode", {bb.state_dbg, bb.retire}, {4'd2, 1'b1});
        step();
        chk("b_nop_done", {bb.state_dbg, bb.retire_cnt, bb.illegal}, {4'd1, 32'd2, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
